// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/exec requesters sharing one fixed-wait-state memory port.
// Optional macro ARB_ROUND_ROBIN_EN alternates grants on contention; default is fixed exec priority.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        boot,
    input  logic        f_req,
    input  logic [19:0] f_addr,
    input  logic        f_byte,
    output logic        f_ack,
    output logic [15:0] f_rdata,
    input  logic        e_req,
    input  logic        e_we,
    input  logic [19:0] e_addr,
    input  logic        e_byte,
    input  logic [15:0] e_wdata,
    output logic        e_ack,
    output logic [15:0] e_rdata,
    output logic [19:0] m_addr,
    output logic        m_byte,
    output logic        m_we,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    output logic        busy,
    output logic        gnt_exec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        f_ack_r;
    logic        e_ack_r;
    logic [15:0] f_rdata_r;
    logic [15:0] e_rdata_r;
    logic [19:0] m_addr_r;
    logic        m_byte_r;
    logic        m_we_r;
    logic [15:0] m_wdata_r;
    logic        busy_r;
    logic        gnt_exec_r;
    logic        exec_wins_s;

    // Pick the winner of the current IDLE-cycle requests.
    always_comb begin
        exec_wins_s = 1'b0;
        if (e_req && f_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // gnt_exec_r resets to 0, so the first contention goes to exec.
            exec_wins_s = ~gnt_exec_r;
`else
            exec_wins_s = 1'b1;
`endif
        end else if (e_req) begin
            exec_wins_s = 1'b1;
        end else begin
            exec_wins_s = 1'b0;
        end
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk or negedge boot) begin
        if (!boot) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            f_ack_r    <= 1'b0;
            e_ack_r    <= 1'b0;
            f_rdata_r  <= 16'h0000;
            e_rdata_r  <= 16'h0000;
            m_addr_r   <= 20'h00000;
            m_byte_r   <= 1'b0;
            m_we_r     <= 1'b1;
            m_wdata_r  <= 16'h0000;
            busy_r     <= 1'b0;
            gnt_exec_r <= 1'b0;
        end else begin
            f_ack_r <= 1'b0;
            e_ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (f_req || e_req) begin
                        gnt_exec_r <= exec_wins_s;
                        m_addr_r   <= exec_wins_s ? e_addr : f_addr;
                        m_byte_r   <= exec_wins_s ? e_byte : f_byte;
                        m_we_r     <= exec_wins_s ? ~e_we : 1'b1;
                        m_wdata_r  <= exec_wins_s ? e_wdata : m_wdata_r;
                        cnt_r      <= CNT_LOAD;
                        busy_r     <= 1'b1;
                        state_r    <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt_r == 4'd0) begin
                        // m_we_r low here means an exec write; writes leave e_rdata alone.
                        if (!gnt_exec_r) begin
                            f_rdata_r <= m_rdata;
                        end else if (m_we_r) begin
                            e_rdata_r <= m_rdata;
                        end else begin
                            e_rdata_r <= e_rdata_r;
                        end
                        m_we_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    // Ack lands in the following IDLE cycle, where a held request re-arbitrates.
                    if (gnt_exec_r) begin
                        e_ack_r <= 1'b1;
                    end else begin
                        f_ack_r <= 1'b1;
                    end
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    m_we_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    cnt_r   <= 4'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign f_ack    = f_ack_r;
    assign e_ack    = e_ack_r;
    assign f_rdata  = f_rdata_r;
    assign e_rdata  = e_rdata_r;
    assign m_addr   = m_addr_r;
    assign m_byte   = m_byte_r;
    assign m_we     = m_we_r;
    assign m_wdata  = m_wdata_r;
    assign busy     = busy_r;
    assign gnt_exec = gnt_exec_r;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: memory access cycles per transfer; legal range 1..15.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 boot  input  1  reset, asynchronous, active-low.
REQ-004 f_req  input  1, f_addr  input  20, f_byte  input  1: fetch request level, address, byte access.
REQ-005 f_ack  output  1, f_rdata  output  16: fetch completion pulse and read data.
REQ-006 e_req  input  1, e_we  input  1 (1 = write), e_addr  input  20, e_byte  input  1, e_wdata  input  16: exec request.
REQ-007 e_ack  output  1, e_rdata  output  16: exec completion pulse and read data.
REQ-008 m_addr  output  20, m_byte  output  1, m_we  output  1 (active-low write), m_wdata  output  16, m_rdata  input  16: memory port.
REQ-009 busy  output  1 (state != IDLE); gnt_exec  output  1 (current or last grant is exec).

Function
REQ-010 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-011 IDLE: if f_req or e_req is sampled high, the arbiter SHALL latch the winner's addr/byte/we/wdata onto the m_* registers, load the wait counter with WAIT_CYCLES-1, and enter ACCESS.
REQ-012 With both requests high in IDLE, exec SHALL win (fixed priority, macro absent).
REQ-013 ACCESS: the counter SHALL decrement each cycle; at zero, m_rdata SHALL be captured into the winner's rdata register and the state SHALL go to DONE.
REQ-014 m_we SHALL be 0 only during ACCESS of an exec write; otherwise 1.
REQ-015 DONE: the winner's ack SHALL be high for exactly one cycle; the state then returns to IDLE; no request is sampled in DONE.
REQ-016 Latency: request sampled at edge N -> ack high in the cycle after edge N+WAIT_CYCLES+1; throughput one transfer per WAIT_CYCLES+2 cycles.
REQ-017 Requesters hold req and operands stable until ack; a req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-018 f_rdata/e_rdata SHALL hold their last captured value until the next completed read of the same requester; writes SHALL NOT update e_rdata.
REQ-019 m_addr/m_byte/m_wdata SHALL hold the last granted values while IDLE/DONE.
REQ-020 f_ack and e_ack SHALL never be high in the same cycle.
REQ-021 A request deasserted during ACCESS SHALL NOT abort the transfer; ack is still issued.

Reset
REQ-022 On boot low: state IDLE, counter 0, f_ack/e_ack 0, m_we 1, m_addr 0, m_byte 0, m_wdata 0, f_rdata/e_rdata 0, gnt_exec 0, busy 0.
REQ-023 Reset asserted mid-ACCESS SHALL abandon the transfer with no ack issued after release.
REQ-024 First grant SHALL be possible in the first IDLE cycle after boot rises.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests SHALL be granted to the requester not granted last (gnt_exec toggles); first contention after reset goes to exec.
REQ-026 Without ARB_ROUND_ROBIN_EN, REQ-012 fixed exec priority applies and no last-grant state is kept.

Verification
REQ-027 WAIT_CYCLES=2, f_req=1, f_addr=0x00100, m_rdata=0xBEEF -> f_ack one cycle 3 cycles after grant edge, f_rdata=0xBEEF, m_we=1 throughout.
REQ-028 e_req=1, e_we=1, e_addr=0xFFFF0, e_wdata=0x1234 -> m_we=0 for exactly 2 cycles, m_addr=0xFFFF0, m_wdata=0x1234, e_ack pulse, e_rdata unchanged.
REQ-029 f_req and e_req held high together for 8 transfers -> macro absent: all 8 acks to exec until e_req drops; macro defined: acks alternate e,f,e,f,...
REQ-030 boot pulsed low during ACCESS of an exec write -> m_we=1 immediately, no e_ack, state IDLE; next request completes normally.
REQ-031 WAIT_CYCLES=1, back-to-back fetch with req held -> f_ack every 3 cycles, never coincident with e_ack.
